// File: rtl/matmul_sequencer_pkg.sv
// rtl/matmul_sequencer_pkg.sv - shared types and constants for the matmul sequencer
// Purpose: FSM state encoding, default tile geometry and watchdog limit.
// Ports: none (package).
package matmul_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WLOAD   = 3'd1,
    WWAIT   = 3'd2,
    WSHIFT  = 3'd3,
    WCOMMIT = 3'd4,
    RUN     = 3'd5,
    FINISH  = 3'd6
  } seq_state_t;

  localparam int DEF_WIDTH_HEIGHT = 16;
  localparam int DEF_ADDR_W       = 8;

  localparam int          WD_W     = 16;
  localparam logic [15:0] WD_LIMIT = 16'hFFFF;

endpackage

// File: rtl/matmul_sequencer_if.sv
// rtl/matmul_sequencer_if.sv - host command channel of the matmul sequencer
// Purpose: bundles the host command handshake and its payload fields.
// Ports: cmd_valid/cmd_ready handshake, cmd_load_w, cmd_w_base, cmd_in_base,
//        cmd_out_base. master = host side, slave = sequencer side.
interface matmul_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_load_w;
  logic [ADDR_W-1:0] cmd_w_base;
  logic [ADDR_W-1:0] cmd_in_base;
  logic [ADDR_W-1:0] cmd_out_base;

  modport master (
    output cmd_valid, cmd_load_w, cmd_w_base, cmd_in_base, cmd_out_base,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_load_w, cmd_w_base, cmd_in_base, cmd_out_base,
    output cmd_ready
  );
endinterface

// File: rtl/matmul_sequencer_seq_row_counter.sv
// rtl/matmul_sequencer_seq_row_counter.sv - load/enable up-counter with terminal flag
// Purpose: weight row counter, and the watchdog counter when enabled.
// Ports: clk, reset (async, active-high), load_i (clear to 0, has priority),
//        en_i (increment), limit_i (terminal value), cnt_o, term_o (cnt_o == limit_i).
module matmul_sequencer_seq_row_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] cnt_o,
  output logic         term_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == limit_i);

endmodule

// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - command-level controller for the systolic-array tile
// Purpose: accepts one host command per matrix multiply and sequences weight
//          load (mem->FIFO), FIFO->array shift, weight commit, input stream and
//          output write, then pulses done.
// Ports: clk, reset (async, active-high); host (command interface, slave);
//        tile controls mem_to_fifo/_done, fifo_to_arr/_done, weight_write,
//        weightMem_rd_en/_rd_addr, active, output_done, inputMem_rd_addr_base,
//        outputMem_wr_addr_base; status busy, done, err.
// Build option: SEQ_WATCHDOG_EN adds a 16-bit wait watchdog driving err.
module matmul_sequencer
  import matmul_sequencer_pkg::*;
#(
  parameter int WIDTH_HEIGHT = DEF_WIDTH_HEIGHT,
  parameter int ADDR_W       = DEF_ADDR_W
) (
  input  logic                           clk,
  input  logic                           reset,
  matmul_sequencer_if.slave              host,
  output logic                           mem_to_fifo,
  input  logic                           mem_to_fifo_done,
  output logic                           fifo_to_arr,
  input  logic                           fifo_to_arr_done,
  output logic [WIDTH_HEIGHT-1:0]        weight_write,
  output logic [WIDTH_HEIGHT-1:0]        weightMem_rd_en,
  output logic [WIDTH_HEIGHT*ADDR_W-1:0] weightMem_rd_addr,
  output logic                           active,
  input  logic                           output_done,
  output logic [WIDTH_HEIGHT*ADDR_W-1:0] inputMem_rd_addr_base,
  output logic [WIDTH_HEIGHT*ADDR_W-1:0] outputMem_wr_addr_base,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int CNT_W = (WIDTH_HEIGHT > 1) ? $clog2(WIDTH_HEIGHT) : 1;

  seq_state_t        state_q;
  logic [ADDR_W-1:0] w_base_q, in_base_q, out_base_q;
  logic              mem_to_fifo_q, fifo_to_arr_q, weight_write_q;
  logic              rd_en_q, active_q, done_q;
  // mem->FIFO done that arrived while the row sweep was still running
  logic              m2f_seen_q;

  logic              accept;
  logic [CNT_W-1:0]  row_cnt;
  logic              row_term;
  logic [ADDR_W-1:0] lane_addr;

  assign accept = (state_q == IDLE) && host.cmd_valid;

  matmul_sequencer_seq_row_counter #(.W(CNT_W)) u_row_cnt (
    .clk     (clk),
    .reset   (reset),
    .load_i  (accept),
    .en_i    (state_q == WLOAD),
    .limit_i (CNT_W'(WIDTH_HEIGHT - 1)),
    .cnt_o   (row_cnt),
    .term_o  (row_term)
  );

`ifdef SEQ_WATCHDOG_EN
  seq_state_t        prev_q;
  logic              err_q;
  logic              wd_entry, wd_wait, wd_term;
  logic [WD_W-1:0]   wd_cnt;

  // First cycle of any state: the counter is being cleared, so its value is stale.
  assign wd_entry = (state_q != prev_q);
  assign wd_wait  = (state_q == WWAIT) || (state_q == WSHIFT) || (state_q == RUN);

  matmul_sequencer_seq_row_counter #(.W(WD_W)) u_wd_cnt (
    .clk     (clk),
    .reset   (reset),
    .load_i  (wd_entry),
    .en_i    (wd_wait),
    .limit_i (WD_LIMIT),
    .cnt_o   (wd_cnt),
    .term_o  (wd_term)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      w_base_q       <= '0;
      in_base_q      <= '0;
      out_base_q     <= '0;
      mem_to_fifo_q  <= 1'b0;
      fifo_to_arr_q  <= 1'b0;
      weight_write_q <= 1'b0;
      rd_en_q        <= 1'b0;
      active_q       <= 1'b0;
      done_q         <= 1'b0;
      m2f_seen_q     <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      prev_q         <= IDLE;
      err_q          <= 1'b0;
`endif
    end else begin
      // Start strobes are single-cycle by construction: cleared every edge
      // unless the transition below sets them.
      mem_to_fifo_q  <= 1'b0;
      fifo_to_arr_q  <= 1'b0;
      weight_write_q <= 1'b0;
      active_q       <= 1'b0;
      done_q         <= 1'b0;

      case (state_q)
        IDLE: begin
          if (host.cmd_valid) begin
            w_base_q   <= host.cmd_w_base;
            in_base_q  <= host.cmd_in_base;
            out_base_q <= host.cmd_out_base;
            m2f_seen_q <= 1'b0;
            if (host.cmd_load_w) begin
              state_q       <= WLOAD;
              mem_to_fifo_q <= 1'b1;
              rd_en_q       <= 1'b1;
            end else begin
              state_q  <= RUN;
              active_q <= 1'b1;
            end
          end
        end
        WLOAD: begin
          if (mem_to_fifo_done) m2f_seen_q <= 1'b1;
          if (row_term) begin
            rd_en_q <= 1'b0;
            state_q <= WWAIT;
          end
        end
        WWAIT: begin
          if (mem_to_fifo_done || m2f_seen_q) begin
            m2f_seen_q    <= 1'b0;
            state_q       <= WSHIFT;
            fifo_to_arr_q <= 1'b1;
          end
        end
        WSHIFT: begin
          if (fifo_to_arr_done) begin
            state_q        <= WCOMMIT;
            weight_write_q <= 1'b1;
          end
        end
        WCOMMIT: begin
          state_q  <= RUN;
          active_q <= 1'b1;
        end
        RUN: begin
          if (output_done) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          rd_en_q <= 1'b0;
        end
      endcase

`ifdef SEQ_WATCHDOG_EN
      prev_q <= state_q;
      // A stuck wait gives up: flag the error and complete the command anyway.
      if (wd_wait && !wd_entry && wd_term) begin
        err_q          <= 1'b1;
        state_q        <= FINISH;
        done_q         <= 1'b1;
        fifo_to_arr_q  <= 1'b0;
        weight_write_q <= 1'b0;
        active_q       <= 1'b0;
        m2f_seen_q     <= 1'b0;
      end
`endif
    end
  end

  assign lane_addr = rd_en_q ? (w_base_q + ADDR_W'(row_cnt)) : '0;

  assign host.cmd_ready          = (state_q == IDLE);
  assign busy                    = (state_q != IDLE);
  assign done                    = done_q;
  assign mem_to_fifo             = mem_to_fifo_q;
  assign fifo_to_arr             = fifo_to_arr_q;
  assign active                  = active_q;
  assign weight_write            = {WIDTH_HEIGHT{weight_write_q}};
  assign weightMem_rd_en         = {WIDTH_HEIGHT{rd_en_q}};
  assign weightMem_rd_addr       = {WIDTH_HEIGHT{lane_addr}};
  assign inputMem_rd_addr_base   = {WIDTH_HEIGHT{in_base_q}};
  assign outputMem_wr_addr_base  = {WIDTH_HEIGHT{out_base_q}};

`ifdef SEQ_WATCHDOG_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
